// File: rtl/eth_stats_poller_axi_if.sv
//==============================================================================
// Module      : eth_stats_poller_axi_if
// Description : AXI4-Lite bundle between the statistics poller (master) and
//               the Ethernet statistics collector's S_AXI port (slave).
// Signals     : aw*/w*/b* write channels, ar*/r* read channels; 12-bit
//               addresses, 32-bit data, 2-bit responses.
// Modports    : master - driven by the poller
//               slave  - driven by the collector (or a bench model)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface eth_stats_poller_axi_if;
    logic [11:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [11:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

`default_nettype wire

// File: rtl/eth_stats_poller_axi.sv
//==============================================================================
// Module      : eth_stats_poller_axi
// Description : AXI4-Lite master that drains the Ethernet statistics
//               collector's sample FIFO. Every POLL_PERIOD cycles it writes
//               FIFO_POP, then reads the 14 sample words and presents one
//               448-bit sample on a valid/ready output.
// Ports       : clk, rst (synchronous, active-high), enable
//               m_axi        - AXI4-Lite master (eth_stats_poller_axi_if.master)
//               sample_data  - {time, tx_bytes, tx_good, tx_bad,
//                               rx_bytes, rx_good, rx_bad}, time in [447:384]
//               sample_valid / sample_ready - output handshake
//               empty_polls  - POPs answered with a non-OKAY response (sat.)
//               err_count    - non-OKAY read responses (sat.)
// Config      : STATS_POLLER_DRAIN_EN - after a delivered sample, POP again
//               immediately until a POP comes back empty.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module eth_stats_poller_axi #(
    parameter logic [11:0] BASE_ADDR   = 12'h000,
    parameter int          POLL_PERIOD = 1000
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  enable,
    eth_stats_poller_axi_if.master     m_axi,
    output      logic [447:0]          sample_data,
    output      logic                  sample_valid,
    input  wire logic                  sample_ready,
    output      logic [15:0]           empty_polls,
    output      logic [15:0]           err_count
);

    localparam int           c_TIMER_W  = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam logic [3:0]   c_LAST_K   = 4'd13;
    localparam logic [1:0]   c_OKAY     = 2'b00;

    localparam logic [2:0]   c_S_WAIT   = 3'd0;
    localparam logic [2:0]   c_S_POP    = 3'd1;
    localparam logic [2:0]   c_S_BRESP  = 3'd2;
    localparam logic [2:0]   c_S_RD     = 3'd3;
    localparam logic [2:0]   c_S_RDATA  = 3'd4;
    localparam logic [2:0]   c_S_OUT    = 3'd5;

    logic [2:0]            r_state;
    logic [2:0]            w_state_next;
    logic [c_TIMER_W-1:0]  r_timer;
    logic                  r_aw_done;
    logic                  r_w_done;
    logic [3:0]            r_k;
    logic [447:0]          r_buf;
    logic [447:0]          w_buf_next;
    logic [8:0]            w_base;
    logic                  w_timer_done;
    logic                  w_aw_hs;
    logic                  w_w_hs;

    assign w_timer_done = (r_timer == c_TIMER_W'(POLL_PERIOD - 1));
    assign w_aw_hs      = m_axi.awvalid & m_axi.awready;
    assign w_w_hs       = m_axi.wvalid  & m_axi.wready;

    // Word k carries the low (even k) or high (odd k) half of 64-bit field
    // k/2; field 0 (time) sits at the top of the sample.
    always_comb begin
        w_base     = 9'd384 - {r_k[3:1], 6'd0} + {3'd0, r_k[0], 5'd0};
        w_buf_next = r_buf;
        w_buf_next[w_base +: 32] = m_axi.rdata;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_WAIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            c_S_WAIT: begin
                if (enable && w_timer_done) begin
                    w_state_next = c_S_POP;
                end
            end
            c_S_POP: begin
                // AW and W may be accepted in either order or together
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    w_state_next = c_S_BRESP;
                end
            end
            c_S_BRESP: begin
                if (m_axi.bvalid) begin
                    w_state_next = (m_axi.bresp == c_OKAY) ? c_S_RD : c_S_WAIT;
                end
            end
            c_S_RD: begin
                if (m_axi.arready) begin
                    w_state_next = c_S_RDATA;
                end
            end
            c_S_RDATA: begin
                if (m_axi.rvalid) begin
                    if (m_axi.rresp != c_OKAY) begin
                        w_state_next = c_S_WAIT;
                    end else if (r_k == c_LAST_K) begin
                        w_state_next = c_S_OUT;
                    end else begin
                        w_state_next = c_S_RD;
                    end
                end
            end
            c_S_OUT: begin
                if (sample_ready) begin
`ifdef STATS_POLLER_DRAIN_EN
                    w_state_next = enable ? c_S_POP : c_S_WAIT;
`else
                    w_state_next = c_S_WAIT;
`endif
                end
            end
            default: w_state_next = c_S_WAIT;
        endcase
    end

    // Output logic
    always_comb begin
        m_axi.awaddr  = BASE_ADDR + 12'h008;
        m_axi.awprot  = 3'b000;
        m_axi.wdata   = 32'd0;
        m_axi.wstrb   = 4'hF;
        m_axi.araddr  = BASE_ADDR + 12'h010 + {6'd0, r_k, 2'b00};
        m_axi.arprot  = 3'b000;
        m_axi.awvalid = (r_state == c_S_POP) && !r_aw_done;
        m_axi.wvalid  = (r_state == c_S_POP) && !r_w_done;
        m_axi.bready  = (r_state == c_S_BRESP);
        m_axi.arvalid = (r_state == c_S_RD);
        m_axi.rready  = (r_state == c_S_RDATA);
        sample_valid  = (r_state == c_S_OUT);
    end

    // Datapath: timer, channel-accept flags, word index, sample assembly
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer     <= '0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_k         <= 4'd0;
            r_buf       <= '0;
            sample_data <= '0;
            empty_polls <= 16'd0;
            err_count   <= 16'd0;
        end else begin
            // Timer only runs in WAIT with enable high; anything else parks it at 0
            if (r_state == c_S_WAIT && enable && !w_timer_done) begin
                r_timer <= r_timer + c_TIMER_W'(1);
            end else begin
                r_timer <= '0;
            end

            if (r_state == c_S_POP) begin
                if (w_aw_hs) r_aw_done <= 1'b1;
                if (w_w_hs)  r_w_done  <= 1'b1;
            end else begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end

            if (r_state == c_S_BRESP && m_axi.bvalid) begin
                r_k <= 4'd0;
                if (m_axi.bresp != c_OKAY && empty_polls != 16'hFFFF) begin
                    empty_polls <= empty_polls + 16'd1;
                end
            end

            if (r_state == c_S_RDATA && m_axi.rvalid) begin
                if (m_axi.rresp != c_OKAY) begin
                    if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                end else begin
                    r_buf <= w_buf_next;
                    r_k   <= r_k + 4'd1;
                    // Publish only a complete sample so the output never shows partial data
                    if (r_k == c_LAST_K) sample_data <= w_buf_next;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_eth_stats_poller_axi.sv
//==============================================================================
// Module      : tb_eth_stats_poller_axi
// Description : Directed self-checking bench for eth_stats_poller_axi with a
//               behavioural AXI4-Lite collector model (FIFO of samples).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_eth_stats_poller_axi;

    localparam int PP = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b0;
    logic         sample_ready = 1'b0;
    logic [447:0] sample_data;
    logic         sample_valid;
    logic [15:0]  empty_polls;
    logic [15:0]  err_count;

    int checks = 0;
    int errors = 0;

    eth_stats_poller_axi_if bus ();

    eth_stats_poller_axi #(
        .BASE_ADDR   (12'h000),
        .POLL_PERIOD (PP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .m_axi        (bus.master),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .empty_polls  (empty_polls),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    // ---------------- collector model ----------------
    int          queued = 0, next_idx = 0, cur_idx = 0;
    int          aw_delay = 0, w_delay = 0, fail_word = -1;
    bit          r_rand = 1'b0;
    int          aw_hs_count = 0;
    logic [11:0] aw_last = 12'hFFF;
    logic [11:0] ar_log[$];

    function automatic logic [31:0] word(input int s, input int k);
        return {8'(s + 1), 8'hA5, 8'h00, 8'(k)};
    endfunction

    // {time, tx_bytes, tx_good, tx_bad, rx_bytes, rx_good, rx_bad}, each {hi, lo}
    function automatic logic [447:0] exp_sample(input int s);
        return {word(s, 1),  word(s, 0),  word(s, 3),  word(s, 2),
                word(s, 5),  word(s, 4),  word(s, 7),  word(s, 6),
                word(s, 9),  word(s, 8),  word(s, 11), word(s, 10),
                word(s, 13), word(s, 12)};
    endfunction

    initial begin
        bit aw_done, w_done, r_pending, hs_aw, hs_w, hs_b, hs_ar, hs_r;
        int aw_wait, w_wait, r_wait, r_k;
        logic p_awvalid, p_wvalid, p_bready, p_arvalid, p_rready;
        aw_done = 0; w_done = 0; r_pending = 0; aw_wait = 0; w_wait = 0; r_wait = 0; r_k = 0;
        p_awvalid = 0; p_wvalid = 0; p_bready = 0; p_arvalid = 0; p_rready = 0;
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
        bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.awready = 0; bus.wready = 0; bus.bvalid = 0;
                bus.arready = 0; bus.rvalid = 0;
                aw_done = 0; w_done = 0; r_pending = 0; aw_wait = 0; w_wait = 0;
                p_awvalid = 0; p_wvalid = 0; p_bready = 0; p_arvalid = 0; p_rready = 0;
            end else begin
                // handshakes that completed at the posedge just passed
                hs_aw = bus.awready && p_awvalid;
                hs_w  = bus.wready  && p_wvalid;
                hs_b  = bus.bvalid  && p_bready;
                hs_ar = bus.arready && p_arvalid;
                hs_r  = bus.rvalid  && p_rready;
                if (hs_aw) begin bus.awready = 0; aw_done = 1; aw_hs_count++; end
                if (hs_w)  begin bus.wready = 0; w_done = 1; end
                if (hs_b) begin
                    bus.bvalid = 0; aw_done = 0; w_done = 0;
                end else if (aw_done && w_done && !bus.bvalid) begin
                    bus.bvalid = 1;
                    if (queued > 0) begin
                        bus.bresp = 2'b00; queued--; cur_idx = next_idx; next_idx++;
                    end else begin
                        bus.bresp = 2'b10;
                    end
                end
                if (hs_r) bus.rvalid = 0;
                if (hs_ar) begin
                    bus.arready = 0; r_pending = 1;
                    r_wait = r_rand ? int'($urandom_range(0, 7)) : 0;
                end
                if (r_pending) begin
                    if (r_wait == 0) begin
                        bus.rvalid = 1;
                        bus.rdata  = word(cur_idx, r_k);
                        bus.rresp  = (r_k == fail_word) ? 2'b10 : 2'b00;
                        r_pending  = 0;
                    end else begin
                        r_wait--;
                    end
                end
                if (bus.awvalid && !aw_done && !bus.awready) begin
                    if (aw_wait >= aw_delay) begin bus.awready = 1; aw_wait = 0; aw_last = bus.awaddr; end
                    else aw_wait++;
                end
                if (bus.wvalid && !w_done && !bus.wready) begin
                    if (w_wait >= w_delay) begin bus.wready = 1; w_wait = 0; end
                    else w_wait++;
                end
                if (bus.arvalid && !bus.arready && !r_pending && !bus.rvalid) begin
                    bus.arready = 1;
                    ar_log.push_back(bus.araddr);
                    r_k = (int'(bus.araddr) - 16) / 4;
                end
                p_awvalid = bus.awvalid; p_wvalid = bus.wvalid; p_bready = bus.bready;
                p_arvalid = bus.arvalid; p_rready = bus.rready;
            end
        end
    end

    // ---------------- bench helpers ----------------
    function automatic bit cond(input int sel);
        case (sel)
            0:       return bus.awvalid === 1'b1;
            1:       return sample_valid === 1'b1;
            2:       return bus.awvalid === 1'b0;
            default: return bus.arvalid === 1'b1;
        endcase
    endfunction

    task automatic wait_cond(input int sel, input int max, output int n, output bit ok);
        n = 0; ok = 0;
        while (n < max) begin
            @(posedge clk); #1; n++;
            if (cond(sel)) begin ok = 1; break; end
        end
    endtask

    task automatic pulse_ready();
        sample_ready = 1'b1;
        @(posedge clk); #1;
        sample_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bit seen;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready, sample_valid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_valids: got %b want 000000",
                     {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready, sample_valid});
        end
        checks++;
        if (sample_data !== 448'd0) begin
            errors++; $display("FAIL reset_data: got %h want 0", sample_data);
        end
        checks++;
        if ({empty_polls, err_count} !== 32'd0) begin
            errors++; $display("FAIL reset_counters: got %h/%h want 0/0", empty_polls, err_count);
        end
        checks++;
        if ({bus.awprot, bus.wdata, bus.wstrb, bus.arprot} !== {3'b000, 32'd0, 4'hF, 3'b000}) begin
            errors++;
            $display("FAIL const_fields: got %h/%h/%h/%h want 0/0/f/0",
                     bus.awprot, bus.wdata, bus.wstrb, bus.arprot);
        end
        rst = 1'b0;
        seen = 0;
        repeat (20) begin @(posedge clk); #1; if (bus.awvalid) seen = 1; end
        checks++;
        if (seen) begin errors++; $display("FAIL idle_disabled: got awvalid want none"); end
    endtask

    task automatic test_first_sample();
        int n; bit ok; logic [11:0] ea;
        ar_log.delete(); queued = 1;
        enable = 1'b1;
        wait_cond(0, 100, n, ok);
        checks++;
        if (n != PP) begin errors++; $display("FAIL first_pop_delay: got %0d want %0d", n, PP); end
        checks++;
        if (bus.awaddr !== 12'h008) begin errors++; $display("FAIL pop_addr: got %h want 008", bus.awaddr); end
        wait_cond(1, 100, n, ok);
        checks++;
        if (n != 30) begin errors++; $display("FAIL sample_latency: got %0d want 30", n); end
        checks++;
        if (ar_log.size() != 14) begin
            errors++; $display("FAIL read_count: got %0d want 14", ar_log.size());
        end else begin
            for (int k = 0; k < 14; k++) begin
                ea = 12'h010 + 12'(4 * k);
                checks++;
                if (ar_log[k] !== ea) begin
                    errors++; $display("FAIL read_addr[%0d]: got %h want %h", k, ar_log[k], ea);
                end
            end
        end
        checks++;
        if (sample_data !== exp_sample(0)) begin
            errors++; $display("FAIL sample0: got %h want %h", sample_data, exp_sample(0));
        end
        checks++;
        if (sample_data[447:384] !== {word(0, 1), word(0, 0)}) begin
            errors++; $display("FAIL sample0_time: got %h want %h", sample_data[447:384], {word(0, 1), word(0, 0)});
        end
        queued = 0;
        pulse_ready();
        checks++;
        if (sample_valid !== 1'b0) begin errors++; $display("FAIL valid_drop: got %b want 0", sample_valid); end
    endtask

    task automatic test_empty_fifo();
        int n, n1, n2, snap; bit ok, seen;
        wait_cond(0, 100, n, ok);
        checks++;
        if (n != PP) begin errors++; $display("FAIL pop_after_out: got %0d want %0d", n, PP); end
        snap = ar_log.size();
        wait_cond(2, 20, n1, ok);
        wait_cond(0, 100, n2, ok);
        // 1 POP + 1 BRESP + POLL_PERIOD cycles in WAIT
        checks++;
        if (n1 + n2 != PP + 2) begin errors++; $display("FAIL empty_repoll: got %0d want %0d", n1 + n2, PP + 2); end
        checks++;
        if (empty_polls !== 16'd1) begin errors++; $display("FAIL empty_polls1: got %0d want 1", empty_polls); end
        checks++;
        if (ar_log.size() != snap) begin errors++; $display("FAIL empty_no_ar: got %0d want %0d", ar_log.size(), snap); end
        enable = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (empty_polls !== 16'd2) begin errors++; $display("FAIL empty_polls2: got %0d want 2", empty_polls); end
        seen = 0;
        repeat (20) begin @(posedge clk); #1; if (bus.awvalid || bus.arvalid) seen = 1; end
        checks++;
        if (seen) begin errors++; $display("FAIL park_after_disable: got activity want none"); end
    endtask

    task automatic test_read_error();
        int n, snap; bit ok, sv_seen, act;
        queued = 1; fail_word = 5; snap = ar_log.size();
        enable = 1'b1;
        wait_cond(0, 100, n, ok);
        sv_seen = 0; n = 0;
        while (err_count !== 16'd1 && n < 200) begin
            @(posedge clk); #1; n++;
            if (sample_valid) sv_seen = 1;
        end
        enable = 1'b0;
        checks++;
        if (err_count !== 16'd1) begin errors++; $display("FAIL err_count: got %0d want 1", err_count); end
        checks++;
        if (ar_log.size() - snap != 6) begin errors++; $display("FAIL err_reads: got %0d want 6", ar_log.size() - snap); end
        act = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.arvalid || bus.awvalid || bus.rready) act = 1;
            if (sample_valid) sv_seen = 1;
        end
        checks++;
        if (sv_seen) begin errors++; $display("FAIL err_no_sample: got sample_valid want none"); end
        checks++;
        if (act) begin errors++; $display("FAIL err_back_to_wait: got activity want none"); end
        fail_word = -1;
    endtask

    task automatic test_backpressure();
        int n, snap; bit ok, stable, seen;
        queued = 1;
        enable = 1'b1;
        wait_cond(1, 200, n, ok);
        snap = aw_hs_count; stable = 1;
        repeat (50) begin
            @(posedge clk); #1;
            if (!(sample_valid === 1'b1 && sample_data === exp_sample(2))) stable = 0;
        end
        checks++;
        if (!stable) begin errors++; $display("FAIL stall_stable: got %b/%h want 1/%h", sample_valid, sample_data, exp_sample(2)); end
        checks++;
        if (aw_hs_count != snap) begin errors++; $display("FAIL stall_no_aw: got %0d want %0d", aw_hs_count, snap); end
        enable = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (sample_valid !== 1'b1) begin errors++; $display("FAIL disable_keeps_out: got %b want 1", sample_valid); end
        pulse_ready();
        seen = 0;
        repeat (20) begin @(posedge clk); #1; if (bus.awvalid || sample_valid) seen = 1; end
        checks++;
        if (seen) begin errors++; $display("FAIL disable_parks: got activity want none"); end
    endtask

    task automatic test_slow_slave();
        int n, bad; bit ok;
        aw_delay = 0; w_delay = 3; r_rand = 1'b1; queued = 1; ar_log.delete(); aw_last = 12'hFFF;
        enable = 1'b1;
        wait_cond(1, 600, n, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL slow_timeout: got no sample want sample"); end
        checks++;
        if (sample_data !== exp_sample(3)) begin
            errors++; $display("FAIL slow_sample: got %h want %h", sample_data, exp_sample(3));
        end
        bad = 0;
        for (int k = 0; k < ar_log.size(); k++) if (ar_log[k] !== 12'h010 + 12'(4 * k)) bad++;
        checks++;
        if (ar_log.size() != 14 || bad != 0) begin
            errors++; $display("FAIL slow_reads: got %0d reads %0d bad want 14/0", ar_log.size(), bad);
        end
        checks++;
        if (aw_last !== 12'h008) begin errors++; $display("FAIL slow_pop_addr: got %h want 008", aw_last); end
        pulse_ready();
        enable = 1'b0;
        w_delay = 0; r_rand = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_back_to_back();
        int cyc, got, r0, r1, nrise; bit prev_aw, seen;
        logic [447:0] gd[3];
        queued = 3; sample_ready = 1'b1; enable = 1'b1;
        cyc = 0; got = 0; nrise = 0; r0 = 0; r1 = 0; prev_aw = 0;
        gd[0] = '0; gd[1] = '0; gd[2] = '0;
        while (cyc < 400) begin
            @(posedge clk); #1; cyc++;
            if (bus.awvalid && !prev_aw) begin
                if (nrise == 0) r0 = cyc; else if (nrise == 1) r1 = cyc;
                nrise++;
            end
            prev_aw = bus.awvalid;
            if (sample_valid && got < 3) begin gd[got] = sample_data; got++; end
`ifdef STATS_POLLER_DRAIN_EN
            if (got == 3 && empty_polls == 16'd3) break;
`else
            if (got == 2) begin enable = 1'b0; break; end
`endif
        end
`ifdef STATS_POLLER_DRAIN_EN
        checks++;
        if (r1 - r0 != 31) begin errors++; $display("FAIL drain_interval: got %0d want 31", r1 - r0); end
        checks++;
        if (gd[2] !== exp_sample(6)) begin errors++; $display("FAIL drain_sample2: got %h want %h", gd[2], exp_sample(6)); end
        checks++;
        if (empty_polls !== 16'd3) begin errors++; $display("FAIL drain_empty: got %0d want 3", empty_polls); end
        seen = 0;
        repeat (6) begin @(posedge clk); #1; if (bus.awvalid) seen = 1; end
        checks++;
        if (seen) begin errors++; $display("FAIL drain_back_to_wait: got awvalid want none"); end
        enable = 1'b0;
`else
        // OUT handshake, then a full POLL_PERIOD window before the next POP
        checks++;
        if (r1 - r0 != 31 + PP) begin errors++; $display("FAIL window_interval: got %0d want %0d", r1 - r0, 31 + PP); end
        seen = 0;
`endif
        checks++;
        if (gd[0] !== exp_sample(4)) begin errors++; $display("FAIL b2b_sample0: got %h want %h", gd[0], exp_sample(4)); end
        checks++;
        if (gd[1] !== exp_sample(5)) begin errors++; $display("FAIL b2b_sample1: got %h want %h", gd[1], exp_sample(5)); end
        sample_ready = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        int n; bit ok, seen;
        queued = 1; enable = 1'b1;
        wait_cond(3, 100, n, ok);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready, sample_valid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_mid_valids: got %b want 000000",
                     {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready, sample_valid});
        end
        rst = 1'b0; enable = 1'b0;
        seen = 0;
        repeat (20) begin @(posedge clk); #1; if (bus.awvalid || bus.arvalid) seen = 1; end
        checks++;
        if (seen) begin errors++; $display("FAIL reset_mid_idle: got activity want none"); end
    endtask

    initial begin
        test_reset();
        test_first_sample();
        test_empty_fifo();
        test_read_error();
        test_backpressure();
        test_slow_slave();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
